pipelined_barrel_shifter: RTL and testbench

- Parametrised, multi-mode barrel shifter split into one register stage per shift level, with a valid/ready handshake on both sides.
- Supports logical left, logical right, arithmetic right and rotate right.
- Sits between the execute-stage operand mux and the writeback path. It replaces the single-mode combinational shifters for wide or high-frequency configurations.
- An opaque tag travels with each operation so the issuing stage can match results to requests.

---
 rtl/pipelined_barrel_shifter.sv | 204 ++++++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Multi-mode barrel shifter: SLL, SRL, SRA and ROR. There is one register stage
// per shift level. Stage k shifts by 2^k when amount bit k is set, LSB first.
// Both sides use a valid/ready handshake, and bubbles collapse. An opaque tag
// travels with each operation so the issuer can match results to requests.
//
// Timing: an operation accepted at rising edge N is loaded into stage 0 at that
// edge. It sits in the last stage, with out_valid high, ready to transfer at
// edge N+SHW. The pipe holds SHW operations in flight.
//
// Optional feature macro: SHIFTER_FLAGS_EN. When it is defined, the block adds
// two result flags:
//   out_zero  - the result is all zeros
//   out_carry - the last bit shifted out (0 when the amount is 0)
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 32,            // power of 2, minimum 4
    parameter  int TAG_W = 4,             // minimum 1
    localparam int SHW   = $clog2(WIDTH)  // derived shift-amount width
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
`ifdef SHIFTER_FLAGS_EN
    output logic             out_zero,
    output logic             out_carry,
`endif
    output logic             busy
);

    // Operation encoding used on in_op.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Payload held by each stage. The full amount rides along; stage k only
    // looks at bit k of it.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        shift_op_e        op;
        logic [TAG_W-1:0] tag;
`ifdef SHIFTER_FLAGS_EN
        logic             carry;
`endif
    } stage_t;

    // One shift level of s bit positions. Callers only pass s in 1..WIDTH/2.
    // SRA fills from the MSB of this level's input, so the sign carries
    // through every level.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input shift_op_e        op,
        input int               s
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << s;
            OP_SRL:  r = d >> s;
            OP_SRA:  r = $signed(d) >>> s;
            OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
            default: r = d;
        endcase
        return r;
    endfunction

    stage_t           stage_q [SHW];
    stage_t           stage_d [SHW];
    logic [SHW-1:0]   vld_q;
    logic [SHW-1:0]   vld_d;

    stage_t           src     [SHW];   // what each stage would load this cycle
    logic [SHW-1:0]   src_vld;
    logic [SHW-1:0]   rdy;             // ready_k: stage k may load this cycle

`ifdef SHIFTER_FLAGS_EN
    logic [SHW-1:0]   sll_idx;
    logic [SHW-1:0]   srx_idx;
    logic             zero_q;
    logic             zero_d;
`endif

    // Stage k is ready when it is empty or the stage after it can take its
    // contents. That reduces to: out_ready is high, or some stage at k or
    // later is empty. The flat form avoids a combinational self-reference.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            rdy[k] = out_ready ||
                     ((vld_q | SHW'((1 << k) - 1)) != {SHW{1'b1}});
        end
    end

    // Sources for each stage: stage 0 takes the request port, and every later
    // stage takes the register before it.
    always_comb begin
        src[0].data = in_data;
        src[0].amt  = in_amt;
        src[0].op   = shift_op_e'(in_op);
        src[0].tag  = in_tag;
        src_vld[0]  = in_valid;
`ifdef SHIFTER_FLAGS_EN
        // WIDTH is 2^SHW, so 0 - amt in SHW bits equals WIDTH - amt.
        sll_idx = '0 - in_amt;
        srx_idx = in_amt - SHW'(1);
        // For ROR the last bit out lands in out_data[WIDTH-1]. That bit is
        // in_data[amt-1], the same bit used for the right shifts.
        if (in_amt == '0) begin
            src[0].carry = 1'b0;
        end else if (shift_op_e'(in_op) == OP_SLL) begin
            src[0].carry = in_data[sll_idx];
        end else begin
            src[0].carry = in_data[srx_idx];
        end
`endif
        for (int k = 1; k < SHW; k++) begin
            src[k]     = stage_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
    end

    // Next state per stage. Load the shifted source when ready; otherwise
    // hold, which keeps out_* stable under backpressure.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            // NOTE: every always_comb output gets a default first, so no path
            // leaves it unassigned and no latch is inferred.
            stage_d[k] = stage_q[k];
            vld_d[k]   = vld_q[k];
            if (rdy[k]) begin
                vld_d[k]   = src_vld[k];
                stage_d[k] = src[k];
                if (src[k].amt[k]) begin
                    stage_d[k].data = shift_level(src[k].data, src[k].op, 1 << k);
                end
            end
        end
    end

    // Stage registers. An asynchronous reset empties the pipe and drops
    // anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            // NOTE: the payload is reset as well, not only the valid bits,
            // because out_data and out_tag must read 0 while in reset.
            for (int k = 0; k < SHW; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // each stage samples the value its neighbour held before the edge.
            vld_q <= vld_d;
            for (int k = 0; k < SHW; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

`ifdef SHIFTER_FLAGS_EN
    // Zero flag for the final stage. It is computed from the value the last
    // stage is about to load and follows that stage's load and hold.
    always_comb begin
        zero_d = zero_q;
        if (rdy[SHW-1]) begin
            zero_d = (stage_d[SHW-1].data == '0);
        end
    end

    // Zero-flag register, cleared by reset like the rest of the output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = stage_q[SHW-1].carry;
`else
    // Default build: the flag ports and their logic are absent.
`endif

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[SHW-1];
    assign out_data  = stage_q[SHW-1].data;
    assign out_tag   = stage_q[SHW-1].tag;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// Testbench for pipelined_barrel_shifter, WIDTH=32, TAG_W=4.
// A scoreboard queue receives an independently modelled result for every
// accepted request. It is popped and compared each time the DUT emits a result.
// Inputs change #1 after the rising edge. All sampling happens on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
`ifdef SHIFTER_FLAGS_EN
    logic             out_zero;
    logic             out_carry;
`endif

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
`ifdef SHIFTER_FLAGS_EN
        .out_zero  (out_zero),
        .out_carry (out_carry),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        zero;
        logic        carry;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    bit          lat_chk  = 1'b1;
    logic [31:0] last_data;
    logic [3:0]  last_tag;
    logic        last_zero;
    logic        last_carry;
    int          last_lat;
    bit          held_v   = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_tag;

    // Reference model: the whole amount is applied in one step.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                          input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = $signed(d) >>> a;
            default: begin
                r = d;
                for (int i = 0; i < int'(a); i++) r = {r[0], r[31:1]};
            end
        endcase
        return r;
    endfunction

    function automatic logic model_carry(input logic [31:0] d, input logic [4:0] a,
                                         input logic [1:0] op);
        if (a == 5'd0) return 1'b0;
        if (op == 2'b00) return d[32 - int'(a)];
        return d[int'(a) - 1];
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one request and hold it until it is accepted (bounded).
    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                        input logic [3:0] tag, output int stalls);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = tag;
        stalls   = 0;
        @(negedge clock);
        while (!in_ready && stalls < 50) begin
            stalls++;
            @(negedge clock);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < 200), 32'd1);
    endtask

    // Scoreboard monitor: push on accept, pop and compare on emit, and check
    // that a stalled result does not change.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", out_data, held_data);
                    check("hold_tag", 32'(out_tag), 32'(held_tag));
                end
                if (out_valid && out_ready) begin
                    check("out_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        last_lat = cyc - e.acc;
                        check("out_data", out_data, e.data);
                        check("out_tag", 32'(out_tag), 32'(e.tag));
                        if (e.lat) check("latency", 32'(last_lat), 32'(SHW));
`ifdef SHIFTER_FLAGS_EN
                        check("out_zero", 32'(out_zero), 32'(e.zero));
                        check("out_carry", 32'(out_carry), 32'(e.carry));
`endif
                    end
                    last_data = out_data;
                    last_tag  = out_tag;
`ifdef SHIFTER_FLAGS_EN
                    last_zero  = out_zero;
                    last_carry = out_carry;
`endif
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    e.data  = model(in_data, in_amt, in_op);
                    e.tag   = in_tag;
                    e.zero  = (e.data == 32'd0);
                    e.carry = model_carry(in_data, in_amt, in_op);
                    e.acc   = cyc;
                    e.lat   = lat_chk;
                    sb.push_back(e);
                end
                held_v    = out_valid && !out_ready;
                held_data = out_data;
                held_tag  = out_tag;
            end
        end
    endtask

    initial begin
        int st;
        int tot;
        int idx;
        int n0;
        bit acc;
        logic [31:0] bp_d [7];

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // SRA sign fill and exact latency.
        send(32'h8000_0000, 5'd4, 2'b10, 4'd3, st);
        drain("sra");
        check("sra_data", last_data, 32'hF800_0000);
        check("sra_tag", 32'(last_tag), 32'd3);
        check("sra_latency", 32'(last_lat), 32'd5);

        // Mode sweep at the amount extremes.
        send(32'h0000_0001, 5'd31, 2'b00, 4'd1, st); drain("sll31");
        check("sll31_data", last_data, 32'h8000_0000);
        send(32'hF000_0000, 5'd28, 2'b01, 4'd2, st); drain("srl28");
        check("srl28_data", last_data, 32'h0000_000F);
        send(32'h0000_0001, 5'd1, 2'b11, 4'd4, st); drain("ror1");
        check("ror1_data", last_data, 32'h8000_0000);
        send(32'h7FFF_FFFF, 5'd31, 2'b10, 4'd5, st); drain("sra31");
        check("sra31_data", last_data, 32'h0000_0000);

        // A zero amount returns the operand unchanged for every op.
        for (int op = 0; op < 4; op++) begin
            send(32'hA5C3_9617, 5'd0, 2'(op), 4'(op), st);
            drain("amt0");
            check("amt0_data", last_data, 32'hA5C3_9617);
        end

        // Back-to-back stream of 8 ops with no stall.
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send($urandom, 5'($urandom), 2'($urandom), 4'(i), st);
            tot += st;
        end
        check("stream_in_ready_stalls", 32'(tot), 32'd0);
        drain("stream");

        // Backpressure: offer 7 ops while out_ready is low.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) bp_d[i] = 32'h1000_0001 * (i + 1);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_data  = bp_d[idx];
            in_amt   = 5'(idx + 3);
            in_op    = 2'(idx);
            in_tag   = 4'(idx + 8);
            @(negedge clock);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd5);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        n0        = n_out;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
        drain("bp");
        check("bp_drained", 32'(n_out - n0), 32'd5);
        lat_chk = 1'b1;

        // Asynchronous reset with 3 ops in flight.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        send(32'h0000_00FF, 5'd1, 2'b00, 4'd1, st);
        send(32'h0000_00FF, 5'd2, 2'b00, 4'd2, st);
        send(32'h0000_00FF, 5'd3, 2'b00, 4'd3, st);
        repeat (4) step();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        n0        = n_out;
        repeat (10) step();
        check("post_rst_no_stale", 32'(n_out - n0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        send(32'h0000_1234, 5'd4, 2'b00, 4'd9, st);
        drain("post_rst");
        check("post_rst_data", last_data, 32'h0001_2340);
        check("post_rst_tag", 32'(last_tag), 32'd9);

`ifdef SHIFTER_FLAGS_EN
        send(32'h0000_0003, 5'd1, 2'b01, 4'd6, st);
        drain("flag_srl");
        check("flag_srl_carry", 32'(last_carry), 32'd1);
        check("flag_srl_zero", 32'(last_zero), 32'd0);
        send(32'h8000_0000, 5'd1, 2'b00, 4'd7, st);
        drain("flag_sll");
        check("flag_sll_data", last_data, 32'h0000_0000);
        check("flag_sll_zero", 32'(last_zero), 32'd1);
        check("flag_sll_carry", 32'(last_carry), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
